// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse character streamer: slot geometry, symbol
// encodings, special slot values, ASCII constants, the streamer state enum and
// the dot/dash pattern to ASCII lookup.
// No ports (package).
// -----------------------------------------------------------------------------
package morse_pkg;

   localparam int SLOT_W    = 10;
   localparam int NUM_SLOTS = 16;
   localparam int SEQ_W     = SLOT_W * NUM_SLOTS;

   localparam logic [1:0] SYM_DOT   = 2'b00;
   localparam logic [1:0] SYM_DASH  = 2'b01;
   localparam logic [1:0] SYM_SPACE = 2'b10;
   localparam logic [1:0] SYM_PAD   = 2'b11;

   localparam logic [SLOT_W-1:0] EMPTY_SLOT = 10'h3FF;
   localparam logic [SLOT_W-1:0] SPACE_SLOT = 10'h2FF;

   localparam logic [7:0] ASCII_SPACE   = 8'h20;
   localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_EMIT,
      ST_DONE
   } state_e;

   // Maps a slot holding 1-5 dot/dash symbols followed only by pads to ASCII.
   // The pattern is keyed as {length, symbols}, first symbol in the MSB of the
   // 5-bit field, dash = 1, unused low bits 0. Anything malformed or not in the
   // table yields '?'.
   function automatic logic [7:0] morse_lookup(input logic [SLOT_W-1:0] slot);
      logic [2:0] len;
      logic [4:0] pat;
      logic       ok;
      logic       seen_pad;
      logic [1:0] sym;
      logic [7:0] res;
      len      = 3'd0;
      pat      = 5'd0;
      ok       = 1'b1;
      seen_pad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         sym = slot[SLOT_W-1-2*i -: 2];
         if (sym == SYM_PAD) begin
            seen_pad = 1'b1;
         end else if (sym == SYM_SPACE || seen_pad) begin
            ok = 1'b0;
         end else begin
            pat[4-i] = sym[0];
            len      = len + 3'd1;
         end
      end
      if (len == 3'd0) ok = 1'b0;
      res = ASCII_UNKNOWN;
      if (ok) begin
         case ({len, pat})
            {3'd2, 5'b01000}: res = 8'h41; // A .-
            {3'd4, 5'b10000}: res = 8'h42; // B -...
            {3'd4, 5'b10100}: res = 8'h43; // C -.-.
            {3'd3, 5'b10000}: res = 8'h44; // D -..
            {3'd1, 5'b00000}: res = 8'h45; // E .
            {3'd4, 5'b00100}: res = 8'h46; // F ..-.
            {3'd3, 5'b11000}: res = 8'h47; // G --.
            {3'd4, 5'b00000}: res = 8'h48; // H ....
            {3'd2, 5'b00000}: res = 8'h49; // I ..
            {3'd4, 5'b01110}: res = 8'h4A; // J .---
            {3'd3, 5'b10100}: res = 8'h4B; // K -.-
            {3'd4, 5'b01000}: res = 8'h4C; // L .-..
            {3'd2, 5'b11000}: res = 8'h4D; // M --
            {3'd2, 5'b10000}: res = 8'h4E; // N -.
            {3'd3, 5'b11100}: res = 8'h4F; // O ---
            {3'd4, 5'b01100}: res = 8'h50; // P .--.
            {3'd4, 5'b11010}: res = 8'h51; // Q --.-
            {3'd3, 5'b01000}: res = 8'h52; // R .-.
            {3'd3, 5'b00000}: res = 8'h53; // S ...
            {3'd1, 5'b10000}: res = 8'h54; // T -
            {3'd3, 5'b00100}: res = 8'h55; // U ..-
            {3'd4, 5'b00010}: res = 8'h56; // V ...-
            {3'd3, 5'b01100}: res = 8'h57; // W .--
            {3'd4, 5'b10010}: res = 8'h58; // X -..-
            {3'd4, 5'b10110}: res = 8'h59; // Y -.--
            {3'd4, 5'b11000}: res = 8'h5A; // Z --..
            {3'd5, 5'b11111}: res = 8'h30; // 0
            {3'd5, 5'b01111}: res = 8'h31; // 1
            {3'd5, 5'b00111}: res = 8'h32; // 2
            {3'd5, 5'b00011}: res = 8'h33; // 3
            {3'd5, 5'b00001}: res = 8'h34; // 4
            {3'd5, 5'b00000}: res = 8'h35; // 5
            {3'd5, 5'b10000}: res = 8'h36; // 6
            {3'd5, 5'b11000}: res = 8'h37; // 7
            {3'd5, 5'b11100}: res = 8'h38; // 8
            {3'd5, 5'b11110}: res = 8'h39; // 9
            default:          res = ASCII_UNKNOWN;
         endcase
      end
      return res;
   endfunction

endpackage

// File: rtl/morse_slot_decoder.sv
// -----------------------------------------------------------------------------
// morse_slot_decoder
// Combinational classification of one 10-bit sequence slot.
// Ports:
//   slot_i  [9:0] in  : five 2-bit symbols, first symbol in [9:8]
//   char_o  [7:0] out : ASCII for the slot (don't care when empty_o)
//   empty_o       out : slot is all pads and produces no character
// -----------------------------------------------------------------------------
module morse_slot_decoder
   import morse_pkg::*;
(
   input  logic [SLOT_W-1:0] slot_i,
   output logic [7:0]        char_o,
   output logic              empty_o
);

   always_comb begin
      empty_o = (slot_i == EMPTY_SLOT);
      if (slot_i == EMPTY_SLOT) begin
         char_o = 8'h00;
      end else if (slot_i == SPACE_SLOT) begin
         char_o = ASCII_SPACE;
      end else begin
         char_o = morse_lookup(slot_i);
      end
   end

endmodule

// File: rtl/morse_char_streamer.sv
// -----------------------------------------------------------------------------
// morse_char_streamer
// Captures a 16-slot Morse sequence on Start and streams one ASCII character
// per non-empty slot over a valid/ready handshake, then pulses Done.
// Ports:
//   Clk              in  : rising-edge clock
//   Reset_n          in  : synchronous active-low reset
//   Start            in  : capture Sequence and begin streaming (IDLE only)
//   Abort            in  : return to IDLE immediately, no Done
//   Sequence [159:0] in  : slot k = Sequence[159-10k -: 10]
//   Ready            in  : downstream accepts Char this cycle
//   CharValid        out : Char holds a character
//   Char     [7:0]   out : ASCII code
//   Busy             out : state is not IDLE
//   Done             out : one-cycle end-of-stream pulse
//   CharCount [4:0]  out : characters accepted in the current/last stream
// -----------------------------------------------------------------------------
module morse_char_streamer
   import morse_pkg::*;
(
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             Abort,
   input  logic [SEQ_W-1:0] Sequence,
   input  logic             Ready,
   output logic             CharValid,
   output logic [7:0]       Char,
   output logic             Busy,
   output logic             Done,
   output logic [4:0]       CharCount
);

   state_e            state_q;
   logic [3:0]        idx_q;
   logic [SEQ_W-1:0]  shadow_q;
   logic [7:0]        char_q;
   logic              valid_q;
   logic              done_q;
   logic [4:0]        count_q;

   logic [3:0]        rev_idx;
   logic [SLOT_W-1:0] cur_slot;
   logic [7:0]        dec_char;
   logic              dec_empty;

   // Slot 0 lives in the most significant bits of the shadow register.
   assign rev_idx  = 4'(NUM_SLOTS - 1) - idx_q;
   assign cur_slot = shadow_q[rev_idx*SLOT_W +: SLOT_W];

   morse_slot_decoder u_dec (
      .slot_i  (cur_slot),
      .char_o  (dec_char),
      .empty_o (dec_empty)
   );

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= 4'd0;
         shadow_q <= '1;
         char_q   <= 8'h00;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
         count_q  <= 5'd0;
      end else if (Abort) begin
         // Count and Char are deliberately left as they are.
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (Start) begin
                  shadow_q <= Sequence;
                  idx_q    <= 4'd0;
                  count_q  <= 5'd0;
                  state_q  <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (dec_empty) begin
                  if (idx_q == 4'(NUM_SLOTS - 1)) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q <= idx_q + 4'd1;
                  end
               end else begin
                  char_q  <= dec_char;
                  valid_q <= 1'b1;
                  state_q <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (Ready) begin
                  count_q <= count_q + 5'd1;
                  valid_q <= 1'b0;
                  if (idx_q == 4'(NUM_SLOTS - 1)) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q   <= idx_q + 4'd1;
                     state_q <= ST_SCAN;
                  end
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign CharValid = valid_q;
   assign Char      = char_q;
   assign Busy      = (state_q != ST_IDLE);
   assign Done      = done_q;
   assign CharCount = count_q;

endmodule
